// File: rtl/btn_hex_counter_debounce.sv
// Alias package kept for file-list compatibility.
// Debounce logic lives in btn_debounce.sv.
package btn_hex_counter_debounce_pkg;
    localparam int UNUSED_ALIAS = 0;
endpackage

// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button hex counter.
// Holds debounce FSM states, default cycle counts and the count width.
package btn_pkg;

    localparam int HEX_W = 4;
    localparam logic [HEX_W-1:0] HEX_MAX = '1;

    localparam int DB_CYCLES_DEF = 1_000_000;
    localparam int REPEAT_DELAY_DEF = 25_000_000;
    localparam int REPEAT_PERIOD_DEF = 5_000_000;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_e;

    // Returns {wrap, next} for a single up or down step.
    function automatic logic [HEX_W:0] step_hex(
        input logic [HEX_W-1:0] v,
        input logic             up
    );
        logic [HEX_W:0] r;
        if (up) begin
            r = {v == HEX_MAX, v + 1'b1};
        end else begin
            r = {v == '0, v - 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Per-key synchroniser + debounce FSM emitting a one-cycle press pulse.
// Ports: i_clk, i_rst_n, i_btn_n (raw, active-low), o_press, o_held.
// Auto-repeat in HELD is built only with BTN_AUTO_REPEAT_EN defined.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
`ifdef BTN_AUTO_REPEAT_EN
    ,
    parameter int REPEAT_DELAY_CYCLES = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD_CYCLES = REPEAT_PERIOD_DEF
`endif
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn_n,
    output logic o_press,
    output logic o_held
);

    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    // Raw samples; reset to the released level so a key
    // held through reset is seen as a fresh press.
    logic [1:0] sync_q;
    logic       lvl;

    db_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], i_btn_n};
        end
    end

    assign lvl = ~sync_q[1];

`ifdef BTN_AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES)
                        ? REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
    localparam int RW = $clog2(RMAX + 1);
    localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD_CYCLES - 1);

    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          rep_run_q, rep_run_d;
    logic          rep_hit;

    // First repeat waits the long delay, later ones the period.
    assign rep_hit = rep_run_q ? (rep_cnt_q == PER_LAST)
                               : (rep_cnt_q == DLY_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rep_cnt_q <= '0;
            rep_run_q <= 1'b0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
            rep_run_q <= rep_run_d;
        end
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
        rep_cnt_d = rep_cnt_q;
        rep_run_d = rep_run_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (lvl) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!lvl) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    press_d = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
                    rep_cnt_d = '0;
                    rep_run_d = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!lvl) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end else begin
`ifdef BTN_AUTO_REPEAT_EN
                    if (rep_hit) begin
                        press_d   = 1'b1;
                        rep_cnt_d = '0;
                        rep_run_d = 1'b1;
                    end else begin
                        rep_cnt_d = rep_cnt_q + 1'b1;
                    end
`endif
                end
            end
            RELEASE_WAIT: begin
                // Repeat state is left untouched here so a
                // bounce back into HELD resumes the schedule.
                if (lvl) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
`ifdef BTN_AUTO_REPEAT_EN
                    rep_cnt_d = '0;
                    rep_run_d = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign o_press = press_q;
    assign o_held  = (state_q == HELD) || (state_q == RELEASE_WAIT);

endmodule

// File: rtl/btn_hex_counter.sv
// Two-key debounced up/down 4-bit counter with step and wrap strobes.
// Ports: i_clk, i_rst_n, i_btn_up_n, i_btn_dn_n, i_clear,
//        o_hex[3:0], o_step, o_wrap. Option: BTN_AUTO_REPEAT_EN.
module btn_hex_counter
    import btn_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
`ifdef BTN_AUTO_REPEAT_EN
    ,
    parameter int REPEAT_DELAY_CYCLES = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD_CYCLES = REPEAT_PERIOD_DEF
`endif
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_btn_up_n,
    input  logic             i_btn_dn_n,
    input  logic             i_clear,
    output logic [HEX_W-1:0] o_hex,
    output logic             o_step,
    output logic             o_wrap
);

    logic       up_ev, dn_ev;
    logic [1:0] held_unused;

    btn_debounce #(
        .DB_CYCLES(DB_CYCLES)
`ifdef BTN_AUTO_REPEAT_EN
        ,
        .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
        .REPEAT_PERIOD_CYCLES(REPEAT_PERIOD_CYCLES)
`endif
    ) u_up (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_btn_n(i_btn_up_n),
        .o_press(up_ev),
        .o_held (held_unused[0])
    );

    btn_debounce #(
        .DB_CYCLES(DB_CYCLES)
`ifdef BTN_AUTO_REPEAT_EN
        ,
        .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
        .REPEAT_PERIOD_CYCLES(REPEAT_PERIOD_CYCLES)
`endif
    ) u_dn (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_btn_n(i_btn_dn_n),
        .o_press(dn_ev),
        .o_held (held_unused[1])
    );

    logic [HEX_W-1:0] hex_q, hex_d;
    logic             step_q, step_d;
    logic             wrap_q, wrap_d;
    logic             do_clr, do_up, do_dn;

    // Mutually exclusive decode; simultaneous up+down cancels.
    assign do_clr = i_clear;
    assign do_up  = !i_clear && up_ev && !dn_ev;
    assign do_dn  = !i_clear && dn_ev && !up_ev;

    always_comb begin
        hex_d  = hex_q;
        step_d = 1'b0;
        wrap_d = 1'b0;
        unique case (1'b1)
            do_clr: hex_d = '0;
            do_up: begin
                {wrap_d, hex_d} = step_hex(hex_q, 1'b1);
                step_d = 1'b1;
            end
            do_dn: begin
                {wrap_d, hex_d} = step_hex(hex_q, 1'b0);
                step_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hex_q  <= '0;
            step_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            hex_q  <= hex_d;
            step_q <= step_d;
            wrap_q <= wrap_d;
        end
    end

    assign o_hex  = hex_q;
    assign o_step = step_q;
    assign o_wrap = wrap_q;

endmodule

// File: tb/tb_btn_hex_counter.sv
// Directed bench for btn_hex_counter with a step scoreboard.
// Ports: none (top-level bench).
module tb_btn_hex_counter;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       up_n  = 1'b1;
    logic       dn_n  = 1'b1;
    logic       clear = 1'b0;
    logic [3:0] hex;
    logic       step;
    logic       wrap;

    int n_chk  = 0;
    int n_pass = 0;
    int steps;

    logic [4:0] exp_q[$];
    logic [3:0] mdl_hex;

    always #5 clk = ~clk;

    btn_hex_counter #(
        .DB_CYCLES(4)
`ifdef BTN_AUTO_REPEAT_EN
        ,
        .REPEAT_DELAY_CYCLES(20),
        .REPEAT_PERIOD_CYCLES(8)
`endif
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_btn_up_n(up_n),
        .i_btn_dn_n(dn_n),
        .i_clear   (clear),
        .o_hex     (hex),
        .o_step    (step),
        .o_wrap    (wrap)
    );

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h",
                    tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model of one accepted step: {wrap, new value}.
    task automatic expect_step(input logic up);
        logic [4:0] r;
        if (up) r = {mdl_hex == 4'hf, mdl_hex + 4'd1};
        else    r = {mdl_hex == 4'h0, mdl_hex - 4'd1};
        mdl_hex = r[3:0];
        exp_q.push_back(r);
    endtask

    task automatic press(input logic up, input int hold);
        if (up) up_n = 1'b0;
        else    dn_n = 1'b0;
        expect_step(up);
        tick(hold);
        up_n = 1'b1;
        dn_n = 1'b1;
        tick(12);
    endtask

    // Scoreboard: every step strobe must match the next expectation.
    always @(negedge clk) begin
        if (rst_n && step) begin
            check("step_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0)
                check("step_value", {wrap, hex}, exp_q.pop_front());
        end
        if (rst_n && wrap && !step)
            check("wrap_without_step", wrap, 0);
    end

    initial begin
        mdl_hex = 4'h0;
        #12;
        check("rst_hex", hex, 0);
        check("rst_step", step, 0);
        check("rst_wrap", wrap, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(3);

        // Clean press: update exactly at edge k+6.
        up_n = 1'b0;
        expect_step(1'b1);
        tick(6);
        check("clean_pre", hex, 0);
        tick(1);
        check("clean_edge", hex, 1);
        check("clean_step", step, 1);
        tick(1);
        check("clean_step_len", step, 0);
        tick(2);
        up_n = 1'b1;
        tick(15);
        check("clean_release", hex, 1);

        // Bounce then stable press.
        repeat (3) begin
            up_n = 1'b0;
            tick(2);
            up_n = 1'b1;
            tick(2);
        end
        up_n = 1'b0;
        expect_step(1'b1);
        tick(6);
        check("bounce_pre", hex, 1);
        tick(1);
        check("bounce_edge", hex, 2);
        tick(5);
        up_n = 1'b1;
        tick(15);

        repeat (7) press(1'b1, 8);
        check("count_to_9", hex, 9);

        // Asynchronous reset mid-cycle.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_hex", hex, 0);
        check("async_rst_step", step, 0);
        check("async_rst_wrap", wrap, 0);
        mdl_hex = 4'h0;
        @(negedge clk);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // Key held through reset release is a new press.
        up_n = 1'b0;
        tick(3);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        expect_step(1'b1);
        tick(6);
        check("held_rst_pre", hex, 0);
        tick(1);
        check("held_rst_edge", hex, 1);
        up_n = 1'b1;
        tick(15);

        // Wrap both ways.
        press(1'b0, 8);
        press(1'b0, 8);
        check("wrap_down", hex, 15);
        press(1'b1, 8);
        check("wrap_up", hex, 0);
        press(1'b0, 8);
        check("wrap_down2", hex, 15);

        repeat (6) press(1'b1, 8);
        check("count_to_5", hex, 5);

        // Both keys on the same edge cancel.
        up_n = 1'b0;
        dn_n = 1'b0;
        steps = 0;
        repeat (10) begin
            tick(1);
            steps += int'(step);
        end
        up_n = 1'b1;
        dn_n = 1'b1;
        repeat (15) begin
            tick(1);
            steps += int'(step);
        end
        check("both_hex", hex, 5);
        check("both_nostep", steps, 0);

        // Clear on the same cycle as an up event.
        up_n = 1'b0;
        tick(6);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        mdl_hex = 4'h0;
        check("clear_hex", hex, 0);
        check("clear_step", step, 0);
        tick(3);
        up_n = 1'b1;
        tick(15);
        check("clear_after", hex, 0);

        // Long hold: auto-repeat only when built in.
        up_n = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
        repeat (4) expect_step(1'b1);
`else
        expect_step(1'b1);
`endif
        tick(44);
        up_n = 1'b1;
        tick(20);
`ifdef BTN_AUTO_REPEAT_EN
        check("hold_hex", hex, 4);
`else
        check("hold_hex", hex, 1);
`endif
        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
